// File: rtl/trisc_pkg.sv
// Shared TRISC definitions: bus widths and the program loader state encoding.
package trisc_pkg;

  localparam int TRISC_ADDR_W = 4;
  localparam int TRISC_DATA_W = 8;

  typedef logic [2:0] loader_state_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_VREAD = 3'd2;
  localparam logic [2:0] ST_VCMP  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/checksum_acc.sv
// Clearable modulo-2^W accumulator; clear has priority over add.
module checksum_acc #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] sum
);

  logic [W-1:0] sum_reg;

  always_ff @(posedge clk) begin
    if (srst || clr) begin
      sum_reg <= '0;
    end else if (en) begin
      sum_reg <= sum_reg + din;
    end
  end

  assign sum = sum_reg;

endmodule

// File: rtl/trisc_program_loader.sv
// Streams a 16-byte program image into the TRISC RAM, then reads it back
// and compares a mod-256 checksum against the streamed bytes.
module trisc_program_loader
  import trisc_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = TRISC_ADDR_W,
  parameter int DATA_W = TRISC_DATA_W
) (
  input  logic              SysClock,
  input  logic              Clear,
  input  logic              Start,
  input  logic              InValid,
  input  logic [DATA_W-1:0] InData,
  output logic              InReady,
  output logic [ADDR_W-1:0] RamAddr,
  output logic [DATA_W-1:0] RamData,
  output logic              RamWren,
  input  logic [DATA_W-1:0] RamQ,
  output logic              Busy,
  output logic              HoldCPU,
  output logic              Done,
  output logic              VerifyErr,
  output logic [7:0]        Checksum
);

  localparam int CNT_W = ADDR_W + 1;

  loader_state_t     state_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [ADDR_W-1:0] ram_addr_reg;
  logic [DATA_W-1:0] ram_data_reg;
  logic              ram_wren_reg;
  logic              done_reg;
  logic              verify_err_reg;

  logic       handshake;
  logic       start_load;
  logic       rd_add;
  logic [7:0] rd_sum;
  logic [7:0] rd_final;

  assign InReady    = (state_reg == ST_LOAD) && (count_reg < CNT_W'(DEPTH));
  assign handshake  = InValid && InReady;
  assign start_load = (state_reg == ST_IDLE) && Start;

  // RamQ lags RamAddr by one cycle: skip the first VREAD cycle, catch word 15 in VCMP.
  assign rd_add   = ((state_reg == ST_VREAD) && (ram_addr_reg != '0)) ||
                    (state_reg == ST_VCMP);
  assign rd_final = rd_sum + RamQ;

  checksum_acc #(.W(8)) u_load_sum (
    .clk  (SysClock),
    .srst (Clear),
    .clr  (start_load),
    .en   (handshake),
    .din  (InData),
    .sum  (Checksum)
  );

  checksum_acc #(.W(8)) u_read_sum (
    .clk  (SysClock),
    .srst (Clear),
    .clr  (start_load),
    .en   (rd_add),
    .din  (RamQ),
    .sum  (rd_sum)
  );

  always_ff @(posedge SysClock) begin
    if (Clear) begin
      state_reg      <= ST_IDLE;
      count_reg      <= '0;
      ram_addr_reg   <= '0;
      ram_data_reg   <= '0;
      ram_wren_reg   <= 1'b0;
      done_reg       <= 1'b0;
      verify_err_reg <= 1'b0;
    end else begin
      ram_wren_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (Start) begin
            state_reg      <= ST_LOAD;
            count_reg      <= '0;
            done_reg       <= 1'b0;
            verify_err_reg <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (handshake) begin
            ram_addr_reg <= count_reg[ADDR_W-1:0];
            ram_data_reg <= InData;
            ram_wren_reg <= 1'b1;
            count_reg    <= count_reg + 1'b1;
          end else if (count_reg == CNT_W'(DEPTH)) begin
            // Leave one cycle after the last handshake so word 15 is written first.
            state_reg    <= ST_VREAD;
            ram_addr_reg <= '0;
          end
        end
        ST_VREAD: begin
          if (ram_addr_reg == ADDR_W'(DEPTH - 1)) begin
            state_reg <= ST_VCMP;
          end else begin
            ram_addr_reg <= ram_addr_reg + 1'b1;
          end
        end
        ST_VCMP: begin
          verify_err_reg <= (rd_final != Checksum);
          done_reg       <= 1'b1;
          state_reg      <= ST_DONE;
        end
        ST_DONE: begin
          if (!Start) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign RamAddr   = ram_addr_reg;
  assign RamData   = ram_data_reg;
  assign RamWren   = ram_wren_reg;
  assign Busy      = (state_reg == ST_LOAD) || (state_reg == ST_VREAD) ||
                     (state_reg == ST_VCMP);
  assign HoldCPU   = Busy;
  assign Done      = done_reg;
  assign VerifyErr = verify_err_reg;

endmodule

// File: tb/tb_trisc_program_loader.sv
// Directed bench for trisc_program_loader with a synchronous 16x8 RAM model.
module tb_trisc_program_loader;

  logic       SysClock = 1'b0;
  logic       Clear    = 1'b1;
  logic       Start    = 1'b0;
  logic       InValid  = 1'b0;
  logic [7:0] InData   = 8'h00;
  logic       InReady;
  logic [3:0] RamAddr;
  logic [7:0] RamData;
  logic       RamWren;
  logic [7:0] RamQ;
  logic       Busy;
  logic       HoldCPU;
  logic       Done;
  logic       VerifyErr;
  logic [7:0] Checksum;

  logic [7:0] mem [16];
  logic [7:0] img [16];
  logic       corrupt_en = 1'b0;
  logic       mem_wipe   = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 SysClock = ~SysClock;

  trisc_program_loader dut (
    .SysClock  (SysClock),
    .Clear     (Clear),
    .Start     (Start),
    .InValid   (InValid),
    .InData    (InData),
    .InReady   (InReady),
    .RamAddr   (RamAddr),
    .RamData   (RamData),
    .RamWren   (RamWren),
    .RamQ      (RamQ),
    .Busy      (Busy),
    .HoldCPU   (HoldCPU),
    .Done      (Done),
    .VerifyErr (VerifyErr),
    .Checksum  (Checksum)
  );

  // RAM model; can corrupt address 7 to force a verify error.
  always @(posedge SysClock) begin
    if (mem_wipe) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
    end else if (RamWren) begin
      mem[RamAddr] <= (corrupt_en && RamAddr == 4'd7) ? 8'h00 : RamData;
    end
    RamQ <= mem[RamAddr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic do_load(input bit gappy, input bit poke,
                         input logic [7:0] exp_sum, input bit exp_err);
    int  idx;
    int  cyc;
    int  n;
    bit  v;
    bit  wr_seen;
    logic [7:0] exp_b;
    InValid = 1'b0;
    Start   = 1'b1;
    @(negedge SysClock);
    Start = 1'b0;
    check("ready_up", InReady, 1'b1);
    idx = 0;
    cyc = 0;
    while (idx < 16 && cyc < 64) begin
      check("ready_load", InReady, 1'b1);
      v       = gappy ? (cyc % 2 == 0) : 1'b1;
      InValid = v;
      InData  = v ? img[idx] : 8'hEE;
      @(negedge SysClock);
      if (v) begin
        check("wr", {RamWren, RamAddr, RamData}, {1'b1, idx[3:0], img[idx]});
        idx++;
      end else begin
        check("gap_wren", RamWren, 1'b0);
      end
      cyc++;
    end
    check("load_count", idx, 16);
    InValid = poke;
    check("ready_drop", InReady, 1'b0);
    check("busy_load", {Busy, HoldCPU}, 2'b11);
    n       = 0;
    wr_seen = 1'b0;
    while (!Done && n < 40) begin
      @(negedge SysClock);
      n++;
      wr_seen |= RamWren;
      if (poke && n == 5) Start = 1'b1;
      if (poke && n == 6) Start = 1'b0;
    end
    check("done_lat", n, 18);
    check("verify_nowr", wr_seen, 1'b0);
    check("verify_err", VerifyErr, exp_err);
    check("checksum", Checksum, exp_sum);
    check("busy_done", {Busy, HoldCPU, InReady}, 3'b000);
    if (poke) begin
      Start = 1'b1;
      repeat (3) begin
        @(negedge SysClock);
        check("done_hold", {Done, InReady, RamWren, Busy}, 4'b1000);
      end
      check("sum_frozen", Checksum, exp_sum);
      Start = 1'b0;
    end
    InValid = 1'b0;
    @(negedge SysClock);
    @(negedge SysClock);
    check("idle_held", {Done, VerifyErr, Busy}, {1'b1, exp_err, 1'b0});
    for (int i = 0; i < 16; i++) begin
      exp_b = (corrupt_en && i == 7) ? 8'h00 : img[i];
      check("ram", mem[i], exp_b);
    end
    $display("load gappy=%0d poke=%0d corrupt=%0d sum=%02h err=%0d done_cycles=%0d",
             gappy, poke, corrupt_en, Checksum, VerifyErr, n);
  endtask

  initial begin
    Start   = 1'b1;
    InValid = 1'b1;
    repeat (2) @(negedge SysClock);
    check("reset_out", {InReady, RamAddr, RamData, RamWren, Busy, HoldCPU, Done, VerifyErr, Checksum},
          '0);
    Clear   = 1'b0;
    Start   = 1'b0;
    InValid = 1'b0;
    @(negedge SysClock);
    check("reset_idle", {Busy, InReady}, 2'b00);

    for (int i = 0; i < 16; i++) img[i] = 8'h10 + 8'(i);
    do_load(1'b0, 1'b0, 8'h78, 1'b0);

    mem_wipe = 1'b1;
    @(negedge SysClock);
    mem_wipe = 1'b0;
    do_load(1'b1, 1'b0, 8'h78, 1'b0);

    for (int i = 0; i < 16; i++) img[i] = 8'hFF;
    do_load(1'b0, 1'b0, 8'hF0, 1'b0);

    for (int i = 0; i < 16; i++) img[i] = 8'h10 + 8'(i);
    corrupt_en = 1'b1;
    do_load(1'b0, 1'b0, 8'h78, 1'b1);
    corrupt_en = 1'b0;

    // Abort a load after five bytes.
    for (int i = 0; i < 16; i++) img[i] = 8'h40 + 8'(i);
    Start = 1'b1;
    @(negedge SysClock);
    Start   = 1'b0;
    InValid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      InData = img[k];
      @(negedge SysClock);
    end
    Clear  = 1'b1;
    InData = img[5];
    @(negedge SysClock);
    Clear   = 1'b0;
    InValid = 1'b0;
    check("clr_state", {Busy, RamWren, InReady, HoldCPU}, 4'b0000);
    check("clr_sum", Checksum, 8'h00);
    check("clr_done", {Done, VerifyErr}, 2'b00);
    @(negedge SysClock);
    for (int i = 0; i < 5; i++) check("clr_ram", mem[i], 8'h40 + 8'(i));
    check("clr_ram5", mem[5], 8'h15);
    $display("clear after 5 bytes busy=%0d sum=%02h", Busy, Checksum);

    for (int i = 0; i < 16; i++) img[i] = 8'h10 + 8'(i);
    do_load(1'b0, 1'b1, 8'h78, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
